// File: rtl/game_state_ctrl_pkg.sv
// Shared definitions for the game state controller: state encoding, geometry and game constants.
package game_state_ctrl_pkg;

    localparam int COORD_W      = 10;
    localparam int HALF_PLAYER  = 30;
    localparam int HALF_CAR     = 34;
    localparam int LIVES_INIT   = 3;
    localparam int INVULN_TICKS = 64;
    localparam int SCORE_MAX    = 9999;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_HIT  = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    // Distance between two screen coordinates, widened by one bit so it cannot wrap.
    function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [COORD_W:0] a_ext;
        logic [COORD_W:0] b_ext;
        a_ext = {1'b0, a};
        b_ext = {1'b0, b};
        if (a_ext >= b_ext) begin
            return a_ext - b_ext;
        end else begin
            return b_ext - a_ext;
        end
    endfunction

endpackage

// File: rtl/game_state_ctrl_box_overlap.sv
// Axis-aligned box overlap test between two centres sharing one combined half-size.
module box_overlap
    import game_state_ctrl_pkg::*;
(
    input  logic [COORD_W-1:0] a_x,
    input  logic [COORD_W-1:0] a_y,
    input  logic [COORD_W-1:0] b_x,
    input  logic [COORD_W-1:0] b_y,
    input  logic [COORD_W:0]   half_sum,
    output logic               overlap
);

    logic [COORD_W:0] dx_s;
    logic [COORD_W:0] dy_s;

    // Both axis distances must be within the combined half-size, boundary inclusive.
    always_comb begin
        dx_s    = abs_diff(a_x, b_x);
        dy_s    = abs_diff(a_y, b_y);
        overlap = (dx_s <= half_sum) && (dy_s <= half_sum);
    end

endmodule

// File: rtl/game_state_ctrl.sv
// Game flow controller: start synchroniser, player/car collision detection, lives, score and grace period.
module game_state_ctrl
    import game_state_ctrl_pkg::*;
#(
    parameter int HALF_PLAYER  = game_state_ctrl_pkg::HALF_PLAYER,
    parameter int HALF_CAR     = game_state_ctrl_pkg::HALF_CAR,
    parameter int LIVES_INIT   = game_state_ctrl_pkg::LIVES_INIT,
    parameter int INVULN_TICKS = game_state_ctrl_pkg::INVULN_TICKS,
    parameter int SCORE_MAX    = game_state_ctrl_pkg::SCORE_MAX
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   tick,
    input  logic                   start,
    input  logic [COORD_W-1:0]     xpos,
    input  logic [COORD_W-1:0]     ypos,
    input  logic [4*COORD_W-1:0]   car_x,
    input  logic [4*COORD_W-1:0]   car_y,
    output logic [1:0]             state,
    output logic                   run,
    output logic [13:0]            score,
    output logic [1:0]             lives,
    output logic                   hit_flash
);

    localparam int CNT_W = (INVULN_TICKS > 1) ? $clog2(INVULN_TICKS) : 1;
    localparam logic [COORD_W:0] HALF_SUM = (COORD_W + 1)'(HALF_PLAYER + HALF_CAR);

    logic              start_meta_r;
    logic              start_sync_r;
    logic              start_prev_r;
    logic [2:0]        fill_r;
    logic              start_rise_s;
    logic [3:0]        ovl_s;
    logic              hit_r;
    game_state_e       state_r;
    game_state_e       state_nx_s;
    logic [13:0]       score_r;
    logic [13:0]       score_nx_s;
    logic [1:0]        lives_r;
    logic [1:0]        lives_nx_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [CNT_W-1:0]  cnt_nx_s;

    for (genvar k = 0; k < 4; k++) begin : g_car
        box_overlap u_overlap (
            .a_x      (xpos),
            .a_y      (ypos),
            .b_x      (car_x[COORD_W*k +: COORD_W]),
            .b_y      (car_y[COORD_W*k +: COORD_W]),
            .half_sum (HALF_SUM),
            .overlap  (ovl_s[k])
        );
    end

    // Start synchroniser and edge history; fill_r marks when the history holds real samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_meta_r <= 1'b0;
            start_sync_r <= 1'b0;
            start_prev_r <= 1'b0;
            fill_r       <= 3'b000;
        end else begin
            start_meta_r <= start;
            start_sync_r <= start_meta_r;
            start_prev_r <= start_sync_r;
            fill_r       <= {fill_r[1:0], 1'b1};
        end
    end

    // A button held through reset release is not a press: a low sample must precede the high one.
    assign start_rise_s = start_sync_r & ~start_prev_r & fill_r[2];

    // Registered collision flag, one clock behind the positions.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hit_r <= 1'b0;
        end else begin
            hit_r <= |ovl_s;
        end
    end

    // Next-state, score, lives and grace-counter decisions.
    always_comb begin
        state_nx_s = state_r;
        score_nx_s = score_r;
        lives_nx_s = lives_r;
        cnt_nx_s   = cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (start_rise_s) begin
                    score_nx_s = 14'd0;
                    lives_nx_s = 2'(LIVES_INIT);
                    state_nx_s = ST_PLAY;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_PLAY: begin
                if (hit_r) begin
                    if (lives_r <= 2'd1) begin
                        lives_nx_s = 2'd0;
                        state_nx_s = ST_OVER;
                    end else begin
                        lives_nx_s = lives_r - 2'd1;
                        cnt_nx_s   = CNT_W'(INVULN_TICKS - 1);
                        state_nx_s = ST_HIT;
                    end
                end else if (tick) begin
                    if (score_r >= 14'(SCORE_MAX)) begin
                        score_nx_s = 14'(SCORE_MAX);
                    end else begin
                        score_nx_s = score_r + 14'd1;
                    end
                end else begin
                    state_nx_s = ST_PLAY;
                end
            end
            ST_HIT: begin
                if (tick) begin
                    if (cnt_r == '0) begin
                        state_nx_s = ST_PLAY;
                    end else begin
                        cnt_nx_s = cnt_r - CNT_W'(1);
                    end
                end else begin
                    state_nx_s = ST_HIT;
                end
            end
            ST_OVER: begin
                if (start_rise_s) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_OVER;
                end
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Score and lives registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            score_r <= 14'd0;
            lives_r <= 2'(LIVES_INIT);
        end else begin
            score_r <= score_nx_s;
            lives_r <= lives_nx_s;
        end
    end

    // Invulnerability countdown register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_nx_s;
        end
    end

    assign state     = state_r;
    assign run       = (state_r == ST_PLAY);
    assign hit_flash = (state_r == ST_HIT);
    assign score     = score_r;
    assign lives     = lives_r;

endmodule

// File: tb/tb_game_state_ctrl.sv
// Directed bench for game_state_ctrl: per-cycle comparison against a rule-level game model plus literal checkpoints.
module tb_game_state_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  xpos = 10'd450;
    logic [9:0]  ypos = 10'd250;
    logic [39:0] car_x = 40'd0;
    logic [39:0] car_y = 40'd0;
    logic [1:0]  state;
    logic        run;
    logic [13:0] score;
    logic [1:0]  lives;
    logic        hit_flash;

    int checks = 0;
    int errors = 0;

    game_state_ctrl dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .xpos(xpos), .ypos(ypos), .car_x(car_x), .car_y(car_y),
        .state(state), .run(run), .score(score), .lives(lives), .hit_flash(hit_flash)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit near(input int px, input int py, input int cx, input int cy);
        int dx;
        int dy;
        dx = (px > cx) ? px - cx : cx - px;
        dy = (py > cy) ? py - cy : cy - py;
        return (dx <= 64) && (dy <= 64);
    endfunction

    // Game model: a press acts two clocks after it is sampled, a collision one clock after the positions.
    int m_state, m_score, m_lives, m_cnt, m_k;
    bit m_s1, m_s2, m_s3, m_ovl;
    int n_state, n_score, n_lives, n_cnt;
    bit n_ovl, rise;

    always_comb begin
        n_state = m_state;
        n_score = m_score;
        n_lives = m_lives;
        n_cnt   = m_cnt;
        rise    = (m_k >= 3) && m_s2 && !m_s3;
        if (m_state == 0) begin
            if (rise) begin
                n_score = 0;
                n_lives = 3;
                n_state = 1;
            end
        end else if (m_state == 1) begin
            if (m_ovl) begin
                n_lives = m_lives - 1;
                if (n_lives <= 0) begin
                    n_lives = 0;
                    n_state = 3;
                end else begin
                    n_state = 2;
                    n_cnt   = 63;
                end
            end else if (tick) begin
                n_score = (m_score + 1 > 9999) ? 9999 : m_score + 1;
            end
        end else if (m_state == 2) begin
            if (tick) begin
                if (m_cnt == 0) n_state = 1;
                else n_cnt = m_cnt - 1;
            end
        end else begin
            if (rise) n_state = 0;
        end
        n_ovl = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (near(int'(xpos), int'(ypos), int'(car_x[c*10 +: 10]), int'(car_y[c*10 +: 10])))
                n_ovl = 1'b1;
        end
    end

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_state <= 0; m_score <= 0; m_lives <= 3; m_cnt <= 0; m_k <= 0;
            m_s1 <= 1'b0; m_s2 <= 1'b0; m_s3 <= 1'b0; m_ovl <= 1'b0;
        end else begin
            m_state <= n_state; m_score <= n_score; m_lives <= n_lives; m_cnt <= n_cnt;
            m_k <= (m_k < 1000) ? m_k + 1 : m_k;
            m_s1 <= start; m_s2 <= m_s1; m_s3 <= m_s2;
            m_ovl <= n_ovl;
        end
    end

    always @(negedge clk) begin
        chk("cyc_state", 32'(state), 32'(m_state));
        chk("cyc_run", 32'(run), 32'(m_state == 1));
        chk("cyc_hit_flash", 32'(hit_flash), 32'(m_state == 2));
        chk("cyc_score", 32'(score), 32'(m_score));
        chk("cyc_lives", 32'(lives), 32'(m_lives));
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            tick = 1'b1;
            step();
        end
        tick = 1'b0;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        repeat (3) step();
        start = 1'b0;
        repeat (3) step();
    endtask

    task automatic set_car(input int k, input int x, input int y);
        car_x[k*10 +: 10] = 10'(x);
        car_y[k*10 +: 10] = 10'(y);
    endtask

    initial begin
        #12;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_lives", 32'(lives), 32'd3);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_run", 32'(run), 32'd0);
        rst = 1'b1;
        repeat (3) step();
        start_pulse();
        chk("start_play", 32'(state), 32'd1);

        do_ticks(10);
        chk("ten_ticks_score", 32'(score), 32'd10);
        chk("ten_ticks_lives", 32'(lives), 32'd3);
        chk("ten_ticks_run", 32'(run), 32'd1);

        set_car(2, 515, 250);
        set_car(3, 450, 185);
        step();
        set_car(2, 0, 0);
        set_car(3, 0, 0);
        repeat (2) step();
        chk("dx65_nohit_lives", 32'(lives), 32'd3);
        chk("dx65_nohit_state", 32'(state), 32'd1);

        set_car(2, 514, 314);
        step();
        step();
        chk("edge_hit_state", 32'(state), 32'd2);
        chk("edge_hit_lives", 32'(lives), 32'd2);
        chk("edge_hit_flash", 32'(hit_flash), 32'd1);

        do_ticks(63);
        chk("grace_state", 32'(state), 32'd2);
        chk("grace_lives", 32'(lives), 32'd2);
        do_ticks(1);
        chk("resume_play", 32'(state), 32'd1);
        step();
        chk("rehit_lives", 32'(lives), 32'd1);
        chk("rehit_state", 32'(state), 32'd2);

        do_ticks(64);
        step();
        chk("over_state", 32'(state), 32'd3);
        chk("over_lives", 32'(lives), 32'd0);
        chk("over_run", 32'(run), 32'd0);
        chk("over_score", 32'(score), 32'd10);

        set_car(2, 0, 0);
        start_pulse();
        chk("idle_state", 32'(state), 32'd0);
        chk("idle_score_held", 32'(score), 32'd10);
        start_pulse();
        chk("replay_state", 32'(state), 32'd1);
        chk("replay_score", 32'(score), 32'd0);
        chk("replay_lives", 32'(lives), 32'd3);

        do_ticks(9998);
        chk("score_9998", 32'(score), 32'd9998);
        do_ticks(3);
        chk("score_sat", 32'(score), 32'd9999);

        set_car(1, 450, 250);
        step();
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk("tick_hit_score", 32'(score), 32'd9999);
        chk("tick_hit_lives", 32'(lives), 32'd2);
        chk("tick_hit_state", 32'(state), 32'd2);

        step();
        #1;
        start = 1'b1;
        rst = 1'b0;
        #1;
        chk("async_rst_state", 32'(state), 32'd0);
        chk("async_rst_lives", 32'(lives), 32'd3);
        chk("async_rst_score", 32'(score), 32'd0);
        chk("async_rst_flash", 32'(hit_flash), 32'd0);
        #10;
        rst = 1'b1;
        set_car(1, 0, 0);
        repeat (10) step();
        chk("held_start_idle", 32'(state), 32'd0);
        start = 1'b0;
        repeat (3) step();
        start_pulse();
        chk("new_edge_play", 32'(state), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_state_ctrl.md
GAME_STATE_CTRL -- requirements
Module: game_state_ctrl

Interface
REQ-001 SHALL have parameters: HALF_PLAYER=30 (player box half-size, px); HALF_CAR=34 (car box half-size, px); LIVES_INIT=3; INVULN_TICKS=64 (post-hit grace, in ticks); SCORE_MAX=9999.
REQ-002 SHALL have ports: clk  in  1  single clock; the slow game clock that also drives the object-motion stage.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 tick  in  1  one-cycle update strobe, one per game update.
REQ-005 start  in  1  start button, already debounced and asynchronous to clk.
REQ-006 xpos, ypos  in  10 each  player box centre, hCount/vCount units.
REQ-007 car_x, car_y  in  40 each  four 10-bit car centres packed; car k occupies bits [10k+9:10k].
REQ-008 state  out  2  current FSM state.
REQ-009 run  out  1  high only in PLAY; gates player and obstacle motion upstream.
REQ-010 score  out  14  binary score.
REQ-011 lives  out  2  remaining lives.
REQ-012 hit_flash  out  1  high throughout HIT; the colour stage tints the player with it.

Function
REQ-013 SHALL pass start through a 2-flop synchroniser, then a rising-edge detector; only start_rise acts.
REQ-014 Car k SHALL overlap the player when |xpos-car_xk| <= HALF_PLAYER+HALF_CAR and |ypos-car_yk| <= HALF_PLAYER+HALF_CAR.
REQ-015 The absolute difference SHALL be computed in 11-bit unsigned arithmetic, with no wrap-around.
REQ-016 The four overlap flags SHALL be ORed and registered; hit_r lags the positions by exactly 1 clk.
REQ-017 States SHALL be IDLE=0, PLAY=1, HIT=2, OVER=3.
REQ-018 IDLE: on start_rise, set score=0 and lives=LIVES_INIT, then go to PLAY.
REQ-019 PLAY, hit_r=1: decrement lives. Go to OVER if the result is 0; otherwise go to HIT and load the invulnerability counter with INVULN_TICKS-1.
REQ-020 PLAY, tick=1 and hit_r=0: increment score, saturating at SCORE_MAX.
REQ-021 PLAY, hit_r and tick in the same cycle: the hit wins and score does not increment.
REQ-022 HIT: each tick decrements the counter; tick at count 0 returns to PLAY. Collisions are ignored; score is frozen.
REQ-023 OVER: score and lives hold; start_rise goes to IDLE.
REQ-024 start_rise in PLAY or HIT SHALL be ignored.
REQ-025 lives SHALL never underflow below 0.
REQ-026 run SHALL equal (state==PLAY); hit_flash SHALL equal (state==HIT). Both are decoded combinationally from the state register.
REQ-027 All state, counter and score updates SHALL occur on the clk rising edge; no outputs are combinational from inputs.

Reset
REQ-028 While rst=0, outputs SHALL be: state=IDLE, run=0, hit_flash=0, score=0, lives=LIVES_INIT. The invulnerability counter, synchroniser, edge detector and hit_r SHALL be 0.
REQ-029 Reset asserted mid-operation SHALL force the REQ-028 values immediately, independent of clk.
REQ-030 The first start_rise SHALL be recognised no earlier than 3 clk after rst deasserts.

Structure
REQ-031 A shared package SHALL hold: the state encoding, HALF_PLAYER, HALF_CAR, LIVES_INIT, INVULN_TICKS, SCORE_MAX and the 10-bit coordinate width.
REQ-032 The overlap test SHALL be one combinational sub-module, box_overlap, instantiated 4 times. Its ports: two centres, combined half-size, overlap out.
REQ-033 FSM, counters and synchroniser SHALL live in game_state_ctrl; one always block per register group.

Verification
REQ-034 Sequence: reset, start pulse, 10 ticks, player (450,250), cars far away -> state=PLAY, score=10, lives=3, run=1.
REQ-035 In PLAY: player (450,250), car2 at (514,314); next cycle car2 at (515,250) -> first position gives a hit: lives=2, state=HIT on clk+2. Second position (dx=65) gives no hit.
REQ-036 After a hit, 64 ticks with a car overlapping -> lives stays 2 during HIT. PLAY resumes after the 64th tick, then the next cycle re-hits: lives=1.
REQ-037 Three hits from lives=3 -> state=OVER, lives=0, run=0, score held. start pulse -> IDLE; second start pulse -> PLAY, score=0, lives=3.
REQ-038 Preload score=9998, 3 ticks -> score=9999. Then tick and hit in the same cycle -> score stays 9999, lives decrements.
REQ-039 rst=0 asserted between clk edges mid-HIT -> outputs match REQ-028 before the next edge. start held high through reset release -> no PLAY entry without a new rising edge.
